// File: rtl/time_bcd_counter.sv
// Time-of-day core: 1 s prescaler, HH:MM:SS as six BCD digits, and a mode/increment time-set FSM.
// Optional hourly chime output is built when CHIME_EN is defined; otherwise chime is tied to 0.
module time_bcd_counter #(
    parameter int CLK_HZ = 1000
) (
    input  logic       clk,
    input  logic       cr,
    input  logic       en,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] ch0,
    output logic [3:0] ch1,
    output logic [3:0] ch2,
    output logic [3:0] ch3,
    output logic [3:0] ch4,
    output logic [3:0] ch5,
    output logic [1:0] set_mode,
    output logic [5:0] dig_blank,
    output logic       chime
);

    localparam int              PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRE_END  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]   PRE_HALF = PW'(CLK_HZ / 2 - 1);

    // set_mode is the FSM state register itself, so it doubles as the state debug view.
    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_SET_HR  = 2'b01,
        S_SET_MIN = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_pre, w_pre_nxt;
    logic            r_blink, w_blink_nxt;
    logic [5:0]      r_blank, w_blank_nxt;
    logic [3:0]      r_s0, r_s1, r_m0, r_m1, r_h0, r_h1;
    logic [3:0]      w_s0_nxt, w_s1_nxt, w_m0_nxt, w_m1_nxt, w_h0_nxt, w_h1_nxt;
    logic [3:0]      w_hinc0, w_hinc1, w_minc0, w_minc1;
    logic            w_pre_end, w_pre_half, w_sec_tick, w_inc;

    always_comb begin
        w_pre_end  = (r_pre == PRE_END);
        w_pre_half = (r_pre == PRE_HALF);
        w_sec_tick = en & w_pre_end;
        w_inc      = key_inc & ~key_mode;

        // Field increments with their own wrap, shared by RUN carry and SET modes.
        w_hinc0 = r_h0 + 4'd1;
        w_hinc1 = r_h1;
        if (r_h1 == 4'd2 && r_h0 == 4'd3) begin
            w_hinc0 = 4'd0;
            w_hinc1 = 4'd0;
        end else if (r_h0 == 4'd9) begin
            w_hinc0 = 4'd0;
            w_hinc1 = r_h1 + 4'd1;
        end
        w_minc0 = r_m0 + 4'd1;
        w_minc1 = r_m1;
        if (r_m0 == 4'd9) begin
            w_minc0 = 4'd0;
            w_minc1 = (r_m1 == 4'd5) ? 4'd0 : r_m1 + 4'd1;
        end

        w_pre_nxt = r_pre;
        if (r_state == S_SET_MIN && key_mode) begin
            w_pre_nxt = '0;
        end else if (en) begin
            w_pre_nxt = w_pre_end ? '0 : r_pre + PW'(1);
        end
        w_blink_nxt = r_blink ^ (en & (w_pre_end | w_pre_half));

        w_state_nxt = r_state;
        case (r_state)
            S_RUN:     if (key_mode) w_state_nxt = S_SET_HR;
            S_SET_HR:  if (key_mode) w_state_nxt = S_SET_MIN;
            S_SET_MIN: if (key_mode) w_state_nxt = S_RUN;
            default:   w_state_nxt = S_RUN;
        endcase

        w_s0_nxt = r_s0;
        w_s1_nxt = r_s1;
        w_m0_nxt = r_m0;
        w_m1_nxt = r_m1;
        w_h0_nxt = r_h0;
        w_h1_nxt = r_h1;
        case (r_state)
            S_RUN: begin
                if (w_sec_tick) begin
                    if (r_s0 != 4'd9) begin
                        w_s0_nxt = r_s0 + 4'd1;
                    end else begin
                        w_s0_nxt = 4'd0;
                        if (r_s1 != 4'd5) begin
                            w_s1_nxt = r_s1 + 4'd1;
                        end else begin
                            w_s1_nxt = 4'd0;
                            w_m0_nxt = w_minc0;
                            w_m1_nxt = w_minc1;
                            if (r_m1 == 4'd5 && r_m0 == 4'd9) begin
                                w_h0_nxt = w_hinc0;
                                w_h1_nxt = w_hinc1;
                            end
                        end
                    end
                end
            end
            S_SET_HR: begin
                if (w_inc) begin
                    w_h0_nxt = w_hinc0;
                    w_h1_nxt = w_hinc1;
                end
            end
            S_SET_MIN: begin
                if (key_mode) begin
                    w_s0_nxt = 4'd0;
                    w_s1_nxt = 4'd0;
                end else if (w_inc) begin
                    w_m0_nxt = w_minc0;
                    w_m1_nxt = w_minc1;
                end
            end
            default: ;
        endcase

        // Blank mask is derived from next-state values so it lines up with set_mode and blink.
        w_blank_nxt = 6'b000000;
        if (w_blink_nxt) begin
            if (w_state_nxt == S_SET_HR)  w_blank_nxt = 6'b110000;
            if (w_state_nxt == S_SET_MIN) w_blank_nxt = 6'b001100;
        end
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_state <= S_RUN;
            r_pre   <= '0;
            r_blink <= 1'b0;
            r_blank <= 6'b000000;
            r_s0    <= 4'd0;
            r_s1    <= 4'd0;
            r_m0    <= 4'd0;
            r_m1    <= 4'd0;
            r_h0    <= 4'd0;
            r_h1    <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_blink <= w_blink_nxt;
            r_blank <= w_blank_nxt;
            r_s0    <= w_s0_nxt;
            r_s1    <= w_s1_nxt;
            r_m0    <= w_m0_nxt;
            r_m1    <= w_m1_nxt;
            r_h0    <= w_h0_nxt;
            r_h1    <= w_h1_nxt;
        end
    end

`ifdef CHIME_EN
    logic r_chime;

    // Sampled from the current time, so it trails the displayed seconds by one clock.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_chime <= 1'b0;
        end else begin
            r_chime <= (r_state == S_RUN) && (r_m1 == 4'd5) && (r_m0 == 4'd9) &&
                       (r_s1 == 4'd5) && (r_s0 >= 4'd5);
        end
    end

    assign chime = r_chime;
`else
    assign chime = 1'b0;
`endif

    assign ch0       = r_s0;
    assign ch1       = r_s1;
    assign ch2       = r_m0;
    assign ch3       = r_m1;
    assign ch4       = r_h0;
    assign ch5       = r_h1;
    assign set_mode  = r_state;
    assign dig_blank = r_blank;

endmodule

// File: tb/tb_time_bcd_counter.sv
// Bench for time_bcd_counter at CLK_HZ=4: a directed vector table plus hand-written
// sequences for rollover, set-mode wrap, async clear and the chime output.
module tb_time_bcd_counter;

    logic       clk;
    logic       cr;
    logic       en;
    logic       key_mode;
    logic       key_inc;
    logic [3:0] ch0, ch1, ch2, ch3, ch4, ch5;
    logic [1:0] set_mode;
    logic [5:0] dig_blank;
    logic       chime;

    int checks = 0;
    int errors = 0;

`ifdef CHIME_EN
    localparam logic CHIME_ON = 1'b1;
`else
    localparam logic CHIME_ON = 1'b0;
`endif

    time_bcd_counter #(.CLK_HZ(4)) dut (
        .clk       (clk),
        .cr        (cr),
        .en        (en),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .ch0       (ch0),
        .ch1       (ch1),
        .ch2       (ch2),
        .ch3       (ch3),
        .ch4       (ch4),
        .ch5       (ch5),
        .set_mode  (set_mode),
        .dig_blank (dig_blank),
        .chime     (chime)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       km;
        logic       ki;
        int         n;
        int         h;
        int         m;
        int         s;
        logic [1:0] mode;
        logic [5:0] blank;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [23:0] bcd(input int h, input int m, input int s);
        bcd = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk(name, {ch5, ch4, ch3, ch2, ch1, ch0}, bcd(h, m, s));
    endtask

    // driver tasks: all input changes happen at the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i);
        key_mode = m;
        key_inc  = i;
        @(negedge clk);
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    task automatic do_reset();
        en       = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        cr       = 1'b0;
        @(negedge clk);
        cr = 1'b1;
    endtask

    // From 00:00:00 RUN: dial in h:m, leaving RUN with seconds 00 and the prescaler at 0.
    task automatic set_time(input int h, input int m);
        en = 1'b0;
        press(1'b1, 1'b0);
        repeat (h) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (m) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4,  0, 0, 1, 2'b00, 6'b000000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8,  0, 0, 3, 2'b00, 6'b000000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 20, 0, 0, 3, 2'b00, 6'b000000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1,  0, 0, 3, 2'b01, 6'b000000};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1,  1, 0, 3, 2'b01, 6'b000000};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1,  2, 0, 3, 2'b01, 6'b000000};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2,  2, 0, 3, 2'b01, 6'b110000};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 20, 2, 0, 3, 2'b01, 6'b110000};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1,  3, 0, 3, 2'b01, 6'b110000};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1,  3, 0, 3, 2'b01, 6'b000000};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1,  3, 0, 3, 2'b10, 6'b000000};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1,  3, 1, 3, 2'b10, 6'b001100};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1,  3, 1, 0, 2'b00, 6'b000000};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 3,  3, 1, 0, 2'b00, 6'b000000};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1,  3, 1, 1, 2'b00, 6'b000000};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1,  3, 1, 1, 2'b00, 6'b000000};

        en       = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        cr       = 1'b0;
        #3;
        chk_time("reset_time", 0, 0, 0);
        chk("reset_mode", 24'(set_mode), 24'(2'b00));
        chk("reset_blank", 24'(dig_blank), 24'(6'b000000));
        chk("reset_chime", 24'(chime), 24'(1'b0));
        @(negedge clk);
        cr = 1'b1;

        // table-driven vectors, each row continues from the previous one
        for (int i = 0; i < 16; i++) begin
            en = vecs[i].en;
            press(vecs[i].km, vecs[i].ki);
            cyc(vecs[i].n - 1);
            chk($sformatf("vec%0d_time", i), {ch5, ch4, ch3, ch2, ch1, ch0},
                bcd(vecs[i].h, vecs[i].m, vecs[i].s));
            chk($sformatf("vec%0d_mode", i), 24'(set_mode), 24'(vecs[i].mode));
            chk($sformatf("vec%0d_blank", i), 24'(dig_blank), 24'(vecs[i].blank));
        end

        // hour field wraps 22,23,00,01 while minutes/seconds hold
        do_reset();
        set_time(22, 5);
        chk_time("set_22_05", 22, 5, 0);
        press(1'b1, 1'b0);
        chk("sethr_mode", 24'(set_mode), 24'(2'b01));
        press(1'b0, 1'b1);
        chk_time("hr_23", 23, 5, 0);
        press(1'b0, 1'b1);
        chk_time("hr_00", 0, 5, 0);
        press(1'b0, 1'b1);
        chk_time("hr_01", 1, 5, 0);

        // minute field wraps 59->00 without touching hours; mode+inc leaves to RUN
        press(1'b1, 1'b0);
        chk("setmin_mode", 24'(set_mode), 24'(2'b10));
        repeat (54) press(1'b0, 1'b1);
        chk_time("min_59", 1, 59, 0);
        press(1'b0, 1'b1);
        chk_time("min_wrap", 1, 0, 0);
        press(1'b1, 1'b1);
        chk("exit_mode", 24'(set_mode), 24'(2'b00));
        chk_time("exit_time", 1, 0, 0);
        en = 1'b1;
        cyc(3);
        chk_time("exit_no_tick", 1, 0, 0);
        cyc(1);
        chk_time("exit_first_tick", 1, 0, 1);

        // full rollover 23:59:58 -> 23:59:59 -> 00:00:00
        do_reset();
        set_time(23, 59);
        en = 1'b1;
        cyc(232);
        chk_time("roll_58", 23, 59, 58);
        chk("chime_58", 24'(chime), 24'(CHIME_ON));
        cyc(3);
        chk_time("roll_58_hold", 23, 59, 58);
        cyc(1);
        chk_time("roll_59", 23, 59, 59);
        cyc(4);
        chk_time("roll_00", 0, 0, 0);
        cyc(1);
        chk("chime_after_roll", 24'(chime), 24'(1'b0));
        chk("roll_mode", 24'(set_mode), 24'(2'b00));

        // async clear mid-count, no clock edge involved
        do_reset();
        set_time(12, 34);
        en = 1'b1;
        cyc(224);
        chk_time("pre_clear", 12, 34, 56);
        #1 cr = 1'b0;
        #1;
        chk_time("async_clear_time", 0, 0, 0);
        chk("async_clear_mode", 24'(set_mode), 24'(2'b00));
        @(negedge clk);
        cr = 1'b1;
        en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
